// File: rtl/otter_io_hub_if.sv
// OTTER IOBUS as seen by a memory-mapped peripheral.
// No handshake: a read is combinational from iobus_addr, and a write commits on the rising clk while iobus_wr=1.
interface otter_io_hub_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;

  modport master (output iobus_addr, output iobus_out, output iobus_wr, input iobus_in);
  modport slave  (input iobus_addr, input iobus_out, input iobus_wr, output iobus_in);
endinterface

// File: rtl/otter_io_hub.sv
// OTTER I/O hub: output registers, synchronised switches, debounced buttons
// and a sticky, maskable button-press interrupt.
module otter_io_hub #(
  parameter logic [31:0] IN_BASE   = 32'h11008000,
  parameter logic [31:0] OUT_BASE  = 32'h1100C000,
  parameter int          NUM_OUT   = 4,
  parameter int          OUT_W     = 16,
  parameter int          SW_W      = 16,
  parameter int          NUM_BTN   = 5,
  parameter int          DB_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     RST_n,
  otter_io_hub_if.slave            bus,
  input  logic [SW_W-1:0]          switches,
  input  logic [NUM_BTN-1:0]       buttons,
  output logic [NUM_OUT*OUT_W-1:0] out_regs,
  output logic                     intr
);
  localparam int CW   = $clog2(DB_CYCLES + 1);
  localparam int IDXW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic [SW_W-1:0]    sw_s1, sw_sync;
  logic [NUM_BTN-1:0] btn_s1, bs, db, db_nxt, rise;
  logic [NUM_BTN-1:0] pending, pend_nxt, mask, clr;
  logic [CW-1:0]      cnt [NUM_BTN];
  logic [CW-1:0]      cnt_nxt [NUM_BTN];
  logic [OUT_W-1:0]   out_q [NUM_OUT];

  logic        in_sel, out_sel;
  logic [31:0] out_off;
  logic [IDXW-1:0] out_idx;
  logic        unused_bits;

  // The input group is assumed aligned to 16 bytes; address bits [3:2] pick the register.
  assign in_sel  = (bus.iobus_addr[31:4] == IN_BASE[31:4]) && (bus.iobus_addr[1:0] == 2'b00);
  assign out_off = bus.iobus_addr - OUT_BASE;
  assign out_sel = (out_off[1:0] == 2'b00) && (out_off[31:2] < 30'(NUM_OUT));
  assign out_idx = out_off[IDXW+1:2];
  assign unused_bits = ^{bus.iobus_out, out_off};

  always_comb begin
    bus.iobus_in = '0;
    if (in_sel) begin
      case (bus.iobus_addr[3:2])
        2'd0:    bus.iobus_in[SW_W-1:0]    = sw_sync;
        2'd1:    bus.iobus_in[NUM_BTN-1:0] = db;
        2'd2:    bus.iobus_in[NUM_BTN-1:0] = pending;
        default: bus.iobus_in[NUM_BTN-1:0] = mask;
      endcase
    end else if (out_sel) begin
      bus.iobus_in[OUT_W-1:0] = out_q[out_idx];
    end
  end

  // A glitch back to the debounced level zeroes the count, so only an unbroken run flips db.
  always_comb begin
    db_nxt = db;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_nxt[i] = '0;
      if (bs[i] != db[i]) begin
        if (cnt[i] == CW'(DB_CYCLES - 1)) db_nxt[i] = bs[i];
        else                              cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  assign rise = db_nxt & ~db;
  assign clr  = (bus.iobus_wr && in_sel && bus.iobus_addr[3:2] == 2'd2)
                ? bus.iobus_out[NUM_BTN-1:0] : '0;
  // OR-ing the rise in after the clear lets a same-edge press survive a W1C.
  assign pend_nxt = (pending & ~clr) | rise;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sw_s1   <= '0;
      sw_sync <= '0;
      btn_s1  <= '0;
      bs      <= '0;
      db      <= '0;
      pending <= '0;
      mask    <= '0;
      intr    <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else begin
      sw_s1   <= switches;
      sw_sync <= sw_s1;
      btn_s1  <= buttons;
      bs      <= btn_s1;
      db      <= db_nxt;
      pending <= pend_nxt;
      intr    <= |(pending & mask);
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= cnt_nxt[i];
      if (bus.iobus_wr && in_sel && bus.iobus_addr[3:2] == 2'd3)
        mask <= bus.iobus_out[NUM_BTN-1:0];
      for (int k = 0; k < NUM_OUT; k++)
        if (bus.iobus_wr && out_sel && out_idx == IDXW'(k))
          out_q[k] <= bus.iobus_out[OUT_W-1:0];
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_regs[k*OUT_W +: OUT_W] = out_q[k];
  end
endmodule

// File: tb/tb_otter_io_hub.sv
// Bench for otter_io_hub: directed register-map checks plus randomized bus and
// button traffic scored against a behavioural model.
module tb_otter_io_hub;
  localparam logic [31:0] IN_BASE  = 32'h11008000;
  localparam logic [31:0] OUT_BASE = 32'h1100C000;
  localparam int NUM_OUT = 4;
  localparam int OUT_W   = 16;
  localparam int SW_W    = 16;
  localparam int NUM_BTN = 5;
  localparam int DB      = 8;
  localparam logic [31:0] A_SW   = IN_BASE;
  localparam logic [31:0] A_BTN  = IN_BASE + 32'h4;
  localparam logic [31:0] A_PEND = IN_BASE + 32'h8;
  localparam logic [31:0] A_MASK = IN_BASE + 32'hC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [SW_W-1:0]          switches;
  logic [NUM_BTN-1:0]       buttons;
  logic [NUM_OUT*OUT_W-1:0] out_regs;
  logic                     intr;

  otter_io_hub_if bus ();

  otter_io_hub #(
    .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .NUM_OUT(NUM_OUT), .OUT_W(OUT_W),
    .SW_W(SW_W), .NUM_BTN(NUM_BTN), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .RST_n(rst_n), .bus(bus), .switches(switches),
    .buttons(buttons), .out_regs(out_regs), .intr(intr)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic rd_valid = 1'b0;
  logic rand_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A button's debounced level follows its synchronised level once that level
  // has been seen unchanged on DB consecutive clock edges.
  logic [SW_W-1:0]    m_sw1, m_sw2;
  logic [NUM_BTN-1:0] m_b1, m_bs, m_db, m_pend, m_mask, m_runv;
  int                 m_run [NUM_BTN];
  logic [OUT_W-1:0]   m_out [NUM_OUT];
  logic               m_intr;

  always @(posedge clk or negedge rst_n) begin : model
    logic n_intr;
    logic [NUM_BTN-1:0] rise, clr;
    if (!rst_n) begin
      m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_bs = '0; m_db = '0;
      m_pend = '0; m_mask = '0; m_runv = '0; m_intr = 1'b0;
      for (int i = 0; i < NUM_BTN; i++) m_run[i] = 0;
      for (int k = 0; k < NUM_OUT; k++) m_out[k] = '0;
    end else begin
      n_intr = |(m_pend & m_mask);
      rise = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (m_bs[i] == m_runv[i]) m_run[i]++;
        else begin m_runv[i] = m_bs[i]; m_run[i] = 1; end
        if (m_bs[i] != m_db[i] && m_run[i] >= DB) begin
          m_db[i] = m_bs[i];
          rise[i] = m_bs[i];
        end
      end
      clr = (bus.iobus_wr && bus.iobus_addr == A_PEND) ? bus.iobus_out[NUM_BTN-1:0] : '0;
      m_pend = (m_pend & ~clr) | rise;
      if (bus.iobus_wr && bus.iobus_addr == A_MASK) m_mask = bus.iobus_out[NUM_BTN-1:0];
      if (bus.iobus_wr && bus.iobus_addr >= OUT_BASE && bus.iobus_addr < OUT_BASE + 4*NUM_OUT
          && bus.iobus_addr[1:0] == 2'b00)
        m_out[(bus.iobus_addr - OUT_BASE) / 4] = bus.iobus_out[OUT_W-1:0];
      m_bs = m_b1; m_b1 = buttons;
      m_sw2 = m_sw1; m_sw1 = switches;
      m_intr = n_intr;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r = '0;
    if (a == A_SW)        r = 32'(m_sw2);
    else if (a == A_BTN)  r = 32'(m_db);
    else if (a == A_PEND) r = 32'(m_pend);
    else if (a == A_MASK) r = 32'(m_mask);
    else if (a >= OUT_BASE && a < OUT_BASE + 4*NUM_OUT && a[1:0] == 2'b00)
      r = 32'(m_out[(a - OUT_BASE) / 4]);
    return r;
  endfunction

  function automatic logic [63:0] model_out_vec();
    logic [63:0] v = '0;
    for (int k = 0; k < NUM_OUT; k++) v[k*OUT_W +: OUT_W] = m_out[k];
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    #2;
    chk("out_regs_cyc", 64'(out_regs), model_out_vec());
    chk("intr_cyc", 64'(intr), 64'(m_intr));
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      else chk("sb_read", 64'(bus.iobus_in), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.iobus_addr = a; bus.iobus_out = d; bus.iobus_wr = 1'b1;
    @(negedge clk);
    bus.iobus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    @(negedge clk);
    bus.iobus_addr = a; bus.iobus_wr = 1'b0;
    exp_q.push_back(model_read(a));
    rd_valid = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, input string name, input logic [31:0] e);
    bus.iobus_addr = a;
    #1;
    chk(name, 64'(bus.iobus_in), 64'(e));
  endtask

  always @(negedge clk)
    if (rand_en && $urandom_range(0, 15) == 0)
      buttons[$urandom_range(0, NUM_BTN-1)] ^= 1'b1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] addr_tab [10];
  initial begin
    addr_tab = '{A_SW, A_BTN, A_PEND, A_MASK, OUT_BASE, OUT_BASE + 32'h4,
                 OUT_BASE + 32'h8, OUT_BASE + 32'hC, OUT_BASE + 32'h10, IN_BASE + 32'h2};
    buttons = '0; switches = '0;
    bus.iobus_addr = '0; bus.iobus_out = '0; bus.iobus_wr = 1'b0;
    tick(3);
    rst_n = 1'b1;
    peek(OUT_BASE, "rst_out0", 32'h0);
    chk("rst_intr", 64'(intr), 64'd0);

    bus_write(OUT_BASE + 32'h4, 32'hDEADBEEF);
    chk("out1_pins", 64'(out_regs[31:16]), 64'hBEEF);
    peek(OUT_BASE + 32'h4, "out1_rd", 32'h0000BEEF);
    bus_write(OUT_BASE + 32'h10, 32'h12345678);
    peek(OUT_BASE + 32'h10, "out_oob_rd", 32'h0);
    chk("out_oob_pins", 64'(out_regs), 64'h0000_0000_BEEF_0000);
    bus_read(OUT_BASE + 32'h4);

    bus_write(A_MASK, 32'h10);
    @(negedge clk); buttons[4] = 1'b1;
    tick(5); buttons[4] = 1'b0;
    tick(20);
    peek(A_BTN, "pulse_btn", 32'h0);
    peek(A_PEND, "pulse_pend", 32'h0);
    chk("pulse_intr", 64'(intr), 64'd0);

    @(negedge clk); buttons[4] = 1'b1;
    tick(9);
    peek(A_BTN, "btn_e9", 32'h0);
    peek(A_PEND, "pend_e9", 32'h0);
    tick(1);
    peek(A_BTN, "btn_e10", 32'h10);
    peek(A_PEND, "pend_e10", 32'h10);
    chk("intr_e10", 64'(intr), 64'd0);
    tick(1);
    chk("intr_e11", 64'(intr), 64'd1);

    @(negedge clk); buttons[0] = 1'b1;
    tick(15);
    peek(A_PEND, "pend_11", 32'h11);
    bus_write(A_PEND, 32'h10);
    peek(A_PEND, "w1c_pend", 32'h01);
    chk("w1c_intr_hold", 64'(intr), 64'd1);
    tick(1);
    chk("w1c_intr_fall", 64'(intr), 64'd0);
    bus_write(A_MASK, 32'h01);
    chk("mask_intr_lag", 64'(intr), 64'd0);
    tick(1);
    chk("mask_intr_rise", 64'(intr), 64'd1);

    @(negedge clk); buttons[2] = 1'b1;
    tick(8);
    bus_write(A_PEND, 32'h4);
    peek(A_PEND, "same_edge_pend", 32'h05);
    bus_write(A_PEND, 32'h1F);
    peek(A_PEND, "clear_all", 32'h0);
    @(negedge clk); buttons = '0;
    tick(20);
    peek(A_BTN, "release_btn", 32'h0);
    peek(A_PEND, "release_pend", 32'h0);

    @(negedge clk); switches = 16'hA5A5;
    tick(1);
    peek(A_SW, "sw_e1", 32'h0);
    tick(1);
    peek(A_SW, "sw_e2", 32'h0000A5A5);
    peek(IN_BASE + 32'h10, "unmapped_10", 32'h0);
    peek(IN_BASE + 32'h2, "unaligned_2", 32'h0);
    peek(OUT_BASE + 32'h2, "out_unaligned", 32'h0);

    rand_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      a = addr_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) switches = SW_W'($urandom);
      if ($urandom_range(0, 9) < 4) bus_write(a, $urandom);
      else bus_read(a);
    end
    rand_en = 1'b0;
    tick(2);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    @(negedge clk); buttons = '0;
    tick(15);
    @(negedge clk); buttons = '1;
    tick(15);
    bus_write(OUT_BASE, 32'hFFFF);
    bus_write(A_MASK, 32'h1F);
    tick(2);
    peek(A_PEND, "pre_rst_pend", 32'h1F);
    chk("pre_rst_intr", 64'(intr), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_out", 64'(out_regs), 64'd0);
    chk("rst_async_intr", 64'(intr), 64'd0);
    peek(A_PEND, "rst_async_pend", 32'h0);
    peek(A_MASK, "rst_async_mask", 32'h0);
    @(negedge clk); rst_n = 1'b1;
    peek(OUT_BASE, "post_rst_out0", 32'h0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/otter_io_hub.md
Name: otter_io_hub

Overview:
- Parametrised memory-mapped I/O block on the OTTER IOBUS.
- Replaces the fixed switch/button/LED decode with:
  - NUM_OUT readable output registers.
  - Synchronised switch input.
  - Per-button debounce.
  - Rising-edge capture into a sticky, maskable interrupt-pending register that drives the MCU intr input.
- Sits between OTTER_MCU (iobus_*) and the board pins.

Parameters:
- IN_BASE, 32'h11008000, base address of the input/control register group.
- OUT_BASE, 32'h1100C000, base address of the output register group.
- NUM_OUT, 4, number of output registers (1..16).
- OUT_W, 16, width of each output register (1..32).
- SW_W, 16, switch input width (1..32).
- NUM_BTN, 5, button count (1..32).
- DB_CYCLES, 8, consecutive stable cycles a button must hold before its debounced state changes (>=1).

Ports:
- clk  in  1  system clock.
- RST_n  in  1  reset, asynchronous, active-low.
- iobus_addr  in  32  bus address from MCU.
- iobus_out  in  32  write data from MCU.
- iobus_wr  in  1  write strobe, sampled on rising clk.
- iobus_in  out  32  read data to MCU.
- switches  in  SW_W  raw switch pins.
- buttons  in  NUM_BTN  raw button pins.
- out_regs  out  NUM_OUT*OUT_W  output registers concatenated; reg k occupies [k*OUT_W +: OUT_W].
- intr  out  1  interrupt request to MCU.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While RST_n=0, all of the following clear to 0:
  - out_regs, intr
  - pending, mask
  - all sync flops, debounced states and debounce counters

  Reset asserted mid-debounce discards the count.
- Register map (word addresses; low 2 address bits must be 00, else the access is unmapped):
  - IN_BASE+0x0 SW: read-only; 2-flop-synchronised switches, zero-extended.
  - IN_BASE+0x4 BTN: read-only; debounced button vector, zero-extended.
  - IN_BASE+0x8 PEND: read returns pending[NUM_BTN-1:0]; write-1-to-clear.
  - IN_BASE+0xC MASK: read/write; low NUM_BTN bits stored.
  - OUT_BASE+4*k, k<NUM_OUT: read/write; write stores iobus_out[OUT_W-1:0]; read zero-extended.
- Reads:
  - iobus_in is purely combinational from iobus_addr and current state; no read side effects.
  - Unmapped addresses, and k>=NUM_OUT, read 0.
- Writes:
  - Occur on the rising clk when iobus_wr=1.
  - Writes to unmapped or read-only addresses are ignored.
- Debounce, per button i:
  - Two-flop synchroniser produces bs[i].
  - Counter width is clog2(DB_CYCLES+1).
  - If bs[i]==db[i]: cnt<=0.
  - Else if cnt==DB_CYCLES-1: db[i]<=bs[i], cnt<=0.
  - Else cnt<=cnt+1.
  - Any glitch back to db[i] restarts the count.
  - db[i] changes DB_CYCLES clocks after bs[i] first differs.
- Edge capture:
  - On the clock edge where db[i] goes 0->1, pending[i]<=1.
  - The 1->0 transition sets nothing.
  - Pending is sticky until cleared by a PEND write with bit i=1.
  - Same-edge set and W1C of the same bit: set wins, bit stays 1.
- intr:
  - Registered: intr <= |(pending & mask) on each rising clk.
  - intr therefore lags a pending or mask change by one clock.
  - Clearing all enabled pending bits drops intr one clock after the write edge.
- Latency, button press: input stable before edge 1.
  - bs valid after edge 2.
  - db and pending set at edge 2+DB_CYCLES.
  - intr high after edge 3+DB_CYCLES (mask bit set).
- Switch read latency: 2 clocks through the synchroniser.
- Widths: write data is truncated to the destination register width; read data is zero-extended to 32 bits.

Test Plan:
- Reset: drive RST_n=0 mid-operation with out_regs, mask and pending non-zero -> all outputs 0 immediately (asynchronous); after release, reading OUT_BASE+0x0 returns 0.
- Output regs: write 0xDEADBEEF to OUT_BASE+0x4 (OUT_W=16) -> out_regs[31:16]=0xBEEF and readback=0x0000BEEF. Write to OUT_BASE+0x10 (k=4, NUM_OUT=4) -> ignored, reads 0.
- Debounce: DB_CYCLES=8, MASK=0x10.
  - Pulse buttons[4] high for 5 clocks -> BTN stays 0, no pending.
  - Hold high -> BTN=0x10 and PEND=0x10 at edge 10; intr=1 at edge 11.
- W1C and mask:
  - With PEND=0x11 and MASK=0x10, write PEND=0x10 -> PEND=0x01 and intr falls one clock after the write edge.
  - Write MASK=0x01 -> intr rises one clock later.
- Simultaneous events: W1C of bit 2 on the same edge that db[2] rises -> PEND bit 2 remains 1.
- Switches / unmapped:
  - switches=0xA5A5 -> SW reads 0x0000A5A5 two clocks later.
  - Read IN_BASE+0x10 or IN_BASE+0x2 -> 0.
  - Button release (1->0) produces no pending bit.
